// File: rtl/parking_occupancy_fsm_if.sv
// ============================================================================
// Module   : parking_occupancy_fsm_if
// Brief    : Beam-sensor inputs and occupancy/status outputs of the gate tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface parking_occupancy_fsm_if #(
  parameter int CW = 4
);
  logic          a;
  logic          b;
  logic [CW-1:0] count;
  logic          car_in;
  logic          car_out;
  logic          full;
  logic          empty;
  logic          err;

  // Sensor side drives the beams and observes the lot status.
  modport master (
    output a, b,
    input  count, car_in, car_out, full, empty, err
  );

  modport slave (
    input  a, b,
    output count, car_in, car_out, full, empty, err
  );
endinterface

`default_nettype wire

// File: rtl/parking_occupancy_fsm.sv
// ============================================================================
// Module   : parking_occupancy_fsm
// Brief    : Decodes beam break/clear order into entries/exits and keeps a
//            saturating occupancy count with full/empty/err status.
// Revision : 1.0
// ============================================================================
`default_nettype none

module parking_occupancy_fsm #(
  parameter int CAPACITY = 15,
  parameter int CW       = 4
) (
  input wire logic                   clk,
  input wire logic                   reset_n,
  parking_occupancy_fsm_if.slave     bus
);

  localparam logic [CW-1:0] CAP  = CW'(CAPACITY);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN1   = 3'd1,
    EN2   = 3'd2,
    EN3   = 3'd3,
    EX1   = 3'd4,
    EX2   = 3'd5,
    EX3   = 3'd6,
    ABORT = 3'd7
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          car_in;
  logic          car_out;
  logic          err;
  logic [1:0]    ab;

  assign ab = {bus.a, bus.b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      car_in  <= 1'b0;
      car_out <= 1'b0;
      err     <= 1'b0;
    end else begin
      car_in  <= 1'b0;
      car_out <= 1'b0;
      err     <= 1'b0;

      // Unlisted sensor codes hold the current state.
      case (state)
        IDLE: begin
          case (ab)
            2'b10:   state <= EN1;
            2'b01:   state <= EX1;
            2'b11:   state <= ABORT;
            default: state <= IDLE;
          endcase
        end

        EN1: begin
          case (ab)
            2'b11:   state <= EN2;
            2'b00:   state <= IDLE;
            2'b01:   state <= ABORT;
            default: state <= EN1;
          endcase
        end

        EN2: begin
          case (ab)
            2'b01:   state <= EN3;
            2'b10:   state <= EN1;
            2'b00:   state <= IDLE;
            default: state <= EN2;
          endcase
        end

        EN3: begin
          case (ab)
            2'b00: begin
              state  <= IDLE;
              car_in <= 1'b1;
              if (count < CAP) begin
                count <= count + ONE;
              end else begin
                err <= 1'b1;
              end
            end
            2'b11:   state <= EN2;
            2'b10:   state <= ABORT;
            default: state <= EN3;
          endcase
        end

        EX1: begin
          case (ab)
            2'b11:   state <= EX2;
            2'b00:   state <= IDLE;
            2'b10:   state <= ABORT;
            default: state <= EX1;
          endcase
        end

        EX2: begin
          case (ab)
            2'b10:   state <= EX3;
            2'b01:   state <= EX1;
            2'b00:   state <= IDLE;
            default: state <= EX2;
          endcase
        end

        EX3: begin
          case (ab)
            2'b00: begin
              state   <= IDLE;
              car_out <= 1'b1;
              if (count != '0) begin
                count <= count - ONE;
              end else begin
                err <= 1'b1;
              end
            end
            2'b11:   state <= EX2;
            2'b01:   state <= ABORT;
            default: state <= EX3;
          endcase
        end

        ABORT: begin
          if (ab == 2'b00) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Flags decode straight from the count register so they track it with no lag.
  assign bus.count   = count;
  assign bus.car_in  = car_in;
  assign bus.car_out = car_out;
  assign bus.err     = err;
  assign bus.full    = (count == CAP);
  assign bus.empty   = (count == '0);

endmodule

`default_nettype wire

// File: tb/tb_parking_occupancy_fsm.sv
// ============================================================================
// Module   : tb_parking_occupancy_fsm
// Brief    : Directed self-checking bench for the parking occupancy tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_parking_occupancy_fsm;

  logic clk;
  logic reset_n;
  int   total;
  int   passed;
  int   n_in;
  int   n_out;
  int   n_err;

  parking_occupancy_fsm_if #(.CW(4)) bus ();

  parking_occupancy_fsm #(
    .CAPACITY (15),
    .CW       (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply ab for n clocks; pulses are tallied from samples 1 ns after each edge.
  task automatic step(input logic [1:0] ab, input int n);
    bus.a = ab[1];
    bus.b = ab[0];
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_in  += int'(bus.car_in);
      n_out += int'(bus.car_out);
      n_err += int'(bus.err);
    end
  endtask

  task automatic clear_tally();
    n_in  = 0;
    n_out = 0;
    n_err = 0;
  endtask

  task automatic entry();
    step(2'b10, 3); step(2'b11, 3); step(2'b01, 3); step(2'b00, 3);
  endtask

  task automatic leave();
    step(2'b01, 3); step(2'b11, 3); step(2'b10, 3); step(2'b00, 3);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    step(2'b00, 2);
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    reset_n = 1'b0;
    bus.a   = 1'b0;
    bus.b   = 1'b0;
    clear_tally();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",   32'(bus.count), 32'd0);
    check("rst_empty",   32'(bus.empty), 32'd1);
    check("rst_full",    32'(bus.full),  32'd0);
    check("rst_car_in",  32'(bus.car_in), 32'd0);
    check("rst_car_out", 32'(bus.car_out), 32'd0);
    check("rst_err",     32'(bus.err),   32'd0);
    reset_n = 1'b1;
    step(2'b00, 3);

    // Entry with latency check on the final 00 edge
    clear_tally();
    step(2'b10, 3); step(2'b11, 3); step(2'b01, 3);
    check("pre_entry_count", 32'(bus.count), 32'd0);
    step(2'b00, 1);
    check("entry_pulse_now", 32'(bus.car_in), 32'd1);
    check("entry_count_now", 32'(bus.count),  32'd1);
    check("entry_empty_now", 32'(bus.empty),  32'd0);
    step(2'b00, 2);
    check("entry_n_in",  32'(n_in),  32'd1);
    check("entry_n_out", 32'(n_out), 32'd0);
    check("entry_n_err", 32'(n_err), 32'd0);

    // Exit back to empty
    clear_tally();
    leave();
    check("exit_n_out", 32'(n_out), 32'd1);
    check("exit_n_in",  32'(n_in),  32'd0);
    check("exit_n_err", 32'(n_err), 32'd0);
    check("exit_count", 32'(bus.count), 32'd0);
    check("exit_empty", 32'(bus.empty), 32'd1);

    // Backout: 10,11,10,00
    clear_tally();
    step(2'b10, 3); step(2'b11, 3); step(2'b10, 3); step(2'b00, 3);
    check("backout_pulses", 32'(n_in + n_out + n_err), 32'd0);
    check("backout_count",  32'(bus.count), 32'd0);

    // Abort via 10,01,00
    clear_tally();
    step(2'b10, 3); step(2'b01, 3); step(2'b00, 3);
    check("abort_pulses", 32'(n_in + n_out + n_err), 32'd0);

    // Both beams from idle, then clear
    clear_tally();
    step(2'b11, 3); step(2'b00, 3);
    check("idle11_pulses", 32'(n_in + n_out + n_err), 32'd0);
    check("idle11_count",  32'(bus.count), 32'd0);

    // Reverse within a sequence: 10,11,01,11,01,00
    clear_tally();
    step(2'b10, 3); step(2'b11, 3); step(2'b01, 3);
    step(2'b11, 3); step(2'b01, 3); step(2'b00, 3);
    check("reverse_n_in",  32'(n_in),  32'd1);
    check("reverse_n_out", 32'(n_out), 32'd0);
    check("reverse_count", 32'(bus.count), 32'd1);

    // Saturation: 16 entries from zero
    do_reset();
    check("sat_start_count", 32'(bus.count), 32'd0);
    clear_tally();
    for (int k = 0; k < 15; k++) entry();
    check("sat15_count", 32'(bus.count), 32'd15);
    check("sat15_full",  32'(bus.full),  32'd1);
    check("sat15_n_in",  32'(n_in),  32'd15);
    check("sat15_n_err", 32'(n_err), 32'd0);
    clear_tally();
    entry();
    check("sat16_n_in",  32'(n_in),  32'd1);
    check("sat16_n_err", 32'(n_err), 32'd1);
    check("sat16_count", 32'(bus.count), 32'd15);
    check("sat16_full",  32'(bus.full),  32'd1);

    // One exit from full drops the flag
    clear_tally();
    leave();
    check("unfull_count", 32'(bus.count), 32'd14);
    check("unfull_full",  32'(bus.full),  32'd0);
    check("unfull_n_err", 32'(n_err), 32'd0);

    // Exit at empty
    do_reset();
    clear_tally();
    leave();
    check("underflow_n_out", 32'(n_out), 32'd1);
    check("underflow_n_err", 32'(n_err), 32'd1);
    check("underflow_count", 32'(bus.count), 32'd0);
    check("underflow_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset while parked in EN3 with count = 5
    for (int k = 0; k < 5; k++) entry();
    check("mid_count5", 32'(bus.count), 32'd5);
    step(2'b10, 3); step(2'b11, 3); step(2'b01, 3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_async_count", 32'(bus.count), 32'd0);
    check("mid_async_empty", 32'(bus.empty), 32'd1);
    #2 reset_n = 1'b1;
    clear_tally();
    step(2'b00, 4);
    check("mid_after_n_in", 32'(n_in), 32'd0);
    check("mid_after_count", 32'(bus.count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
